// File: rtl/fp_adder_pkg.sv
// Shared float helpers for the sequential FP adder: FSM states, binary32 view,
// canonical constants and width-generic classification functions.
package fp_adder_pkg;

  // Widest exponent/fraction fields the classification helpers accept.
  localparam int unsigned MAX_EXP  = 16;
  localparam int unsigned MAX_FRAC = 64;

  // Default (binary32) field widths.
  localparam int unsigned SP_EXP  = 8;
  localparam int unsigned SP_FRAC = 23;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef struct packed {
    logic               sign;
    logic [SP_EXP-1:0]  exp;
    logic [SP_FRAC-1:0] frac;
  } float_t;

  localparam float_t SP_QNAN    = {1'b0, {SP_EXP{1'b1}}, 1'b1, {(SP_FRAC-1){1'b0}}};
  localparam float_t SP_POS_INF = {1'b0, {SP_EXP{1'b1}}, {SP_FRAC{1'b0}}};

  // True when the low ew bits of e are all ones.
  function automatic logic exp_all_ones(input logic [MAX_EXP-1:0] e, input int unsigned ew);
    logic [MAX_EXP-1:0] mask;
    mask = MAX_EXP'((32'd1 << ew) - 32'd1);
    return e == mask;
  endfunction

  function automatic logic is_zero(input logic [MAX_EXP-1:0] e, input logic [MAX_FRAC-1:0] f);
    return (e == '0) && (f == '0);
  endfunction

  function automatic logic is_denorm(input logic [MAX_EXP-1:0] e, input logic [MAX_FRAC-1:0] f);
    return (e == '0) && (f != '0);
  endfunction

  function automatic logic is_nan(input logic [MAX_EXP-1:0] e, input logic [MAX_FRAC-1:0] f,
                                  input int unsigned ew);
    return exp_all_ones(e, ew) && (f != '0);
  endfunction

  function automatic logic is_inf(input logic [MAX_EXP-1:0] e, input logic [MAX_FRAC-1:0] f,
                                  input int unsigned ew);
    return exp_all_ones(e, ew) && (f == '0);
  endfunction

endpackage

// File: rtl/fp_adder_seq_round.sv
// Round-to-nearest-even on a significand with guard/round/sticky bits.
module fp_round_rne
  import fp_adder_pkg::*;
#(
  parameter int unsigned FRACBITS = 23
) (
  input  logic [FRACBITS:0] sig,
  input  logic              guard,
  input  logic              round_bit,
  input  logic              sticky,
  output logic [FRACBITS:0] rounded,
  output logic              carry,
  output logic              inexact
);

  localparam int unsigned RW = FRACBITS + 2;

  logic up;

  // Increment on above-half, or exactly half with an odd LSB.
  always_comb begin
    inexact          = guard | round_bit | sticky;
    up               = guard & (round_bit | sticky | sig[0]);
    {carry, rounded} = {1'b0, sig} + RW'(up);
  end

endmodule

// File: rtl/fp_adder_seq.sv
// Multi-cycle floating-point adder: bit-serial alignment and normalisation,
// RNE rounding, invalid/overflow/inexact flags.
// Define FP_ADDER_DENORM_EN for gradual underflow; otherwise flush-to-zero.
module fp_adder_seq
  import fp_adder_pkg::*;
#(
  parameter int unsigned EXPBITS  = 8,
  parameter int unsigned FRACBITS = 23
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXPBITS+FRACBITS:0] a,
  input  logic [EXPBITS+FRACBITS:0] b,
  input  logic                      sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXPBITS+FRACBITS:0] result,
  output logic                      flag_invalid,
  output logic                      flag_overflow,
  output logic                      flag_inexact
);

  localparam int unsigned W    = 1 + EXPBITS + FRACBITS;
  localparam int unsigned SW   = FRACBITS + 4;   // hidden + fraction + G/R/S
  localparam int unsigned EW   = EXPBITS + 1;    // exponent with carry headroom
  localparam int unsigned MAXD = FRACBITS + 3;   // widest useful alignment shift
  localparam logic [EW-1:0] EXP_MAX = EW'((32'd1 << EXPBITS) - 32'd1);

  typedef struct packed {
    logic                sign;
    logic [EXPBITS-1:0]  exp;
    logic [FRACBITS-1:0] frac;
  } fp_t;

  localparam fp_t QNAN = {1'b0, {EXPBITS{1'b1}}, 1'b1, {(FRACBITS-1){1'b0}}};

  state_t             state;
  fp_t                a_q, b_q;
  logic               sign_r, eff_sub;
  logic [EW-1:0]      exp_r;
  logic [SW:0]        m_r;      // larger operand, then sum (bit SW = carry)
  logic [SW-1:0]      s_r;      // smaller operand being aligned
  logic [EXPBITS-1:0] cnt;

  // Continue normalising while there is a carry or a leading zero above the floor.
  function automatic logic need_norm(input logic [SW:0] m, input logic [EW-1:0] e);
    return m[SW] | (~m[SW-1] & (e > EW'(1)));
  endfunction

  // Unpack-stage signals
  logic               a_nan, b_nan, a_inf, b_inf, spec_c, spec_inv;
  fp_t                spec_res;
  logic [FRACBITS-1:0] fa, fb;
  logic [EXPBITS-1:0] ea, eb, e_l, e_s, diff;
  logic [SW-1:0]      sig_a, sig_b, sig_l, sig_s;
  logic               a_big, lsign, far;

  // Classify operands, pick the larger magnitude and the alignment distance.
  always_comb begin
    a_nan = is_nan(MAX_EXP'(a_q.exp), MAX_FRAC'(a_q.frac), EXPBITS);
    b_nan = is_nan(MAX_EXP'(b_q.exp), MAX_FRAC'(b_q.frac), EXPBITS);
    a_inf = is_inf(MAX_EXP'(a_q.exp), MAX_FRAC'(a_q.frac), EXPBITS);
    b_inf = is_inf(MAX_EXP'(b_q.exp), MAX_FRAC'(b_q.frac), EXPBITS);
    spec_c   = a_nan | b_nan | a_inf | b_inf;
    spec_inv = 1'b0;
    spec_res = QNAN;
    if (!(a_nan | b_nan)) begin
      if (a_inf && b_inf && (a_q.sign != b_q.sign)) begin
        spec_inv = 1'b1;
      end else if (a_inf) begin
        spec_res = a_q;
      end else begin
        spec_res = b_q;
      end
    end
`ifdef FP_ADDER_DENORM_EN
    fa = a_q.frac;
    fb = b_q.frac;
`else
    fa = is_denorm(MAX_EXP'(a_q.exp), MAX_FRAC'(a_q.frac)) ? '0 : a_q.frac;
    fb = is_denorm(MAX_EXP'(b_q.exp), MAX_FRAC'(b_q.frac)) ? '0 : b_q.frac;
`endif
    ea    = (a_q.exp == '0) ? EXPBITS'(1) : a_q.exp;
    eb    = (b_q.exp == '0) ? EXPBITS'(1) : b_q.exp;
    sig_a = {(a_q.exp != '0), fa, 3'b000};
    sig_b = {(b_q.exp != '0), fb, 3'b000};
    a_big = {a_q.exp, fa} >= {b_q.exp, fb};
    if (a_big) begin
      sig_l = sig_a; sig_s = sig_b; e_l = ea; e_s = eb; lsign = a_q.sign;
    end else begin
      sig_l = sig_b; sig_s = sig_a; e_l = eb; e_s = ea; lsign = b_q.sign;
    end
    diff = e_l - e_s;
    far  = 32'(diff) > MAXD;
  end

  // Add/subtract and single-step normalisation datapath.
  logic [SW:0]   sum_c, m_n;
  logic [EW-1:0] e_n;

  always_comb begin
    sum_c = eff_sub ? (m_r - {1'b0, s_r}) : (m_r + {1'b0, s_r});
    if (m_r[SW]) begin
      m_n = {1'b0, m_r[SW:2], m_r[1] | m_r[0]};
      e_n = exp_r + EW'(1);
    end else begin
      m_n = {m_r[SW-1:0], 1'b0};
      e_n = exp_r - EW'(1);
    end
  end

  // Rounding and packing.
  logic [FRACBITS:0]  rnd;
  logic               rnd_carry, rnd_inexact, hid_fin, ovf, tiny;
  logic [EW-1:0]      e_fin;
  logic [EXPBITS-1:0] exp_field;

  fp_round_rne #(.FRACBITS(FRACBITS)) u_round (
    .sig      (m_r[SW-1:3]),
    .guard    (m_r[2]),
    .round_bit(m_r[1]),
    .sticky   (m_r[0]),
    .rounded  (rnd),
    .carry    (rnd_carry),
    .inexact  (rnd_inexact)
  );

  // Post-round exponent, overflow and underflow detection.
  always_comb begin
    e_fin     = rnd_carry ? (exp_r + EW'(1)) : exp_r;
    hid_fin   = rnd_carry | rnd[FRACBITS];
    exp_field = hid_fin ? e_fin[EXPBITS-1:0] : '0;
    ovf       = hid_fin && (e_fin >= EXP_MAX);
`ifdef FP_ADDER_DENORM_EN
    tiny      = 1'b0;
`else
    tiny      = ~m_r[SW-1] && (m_r != '0);
`endif
  end

  // Operation sequencer with registered handshake, result and flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      result        <= '0;
      flag_invalid  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_inexact  <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      sign_r        <= 1'b0;
      eff_sub       <= 1'b0;
      exp_r         <= '0;
      m_r           <= '0;
      s_r           <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= {b[W-1] ^ sub, b[W-2:0]};
            in_ready <= 1'b0;
            state    <= UNPACK;
          end
        end
        UNPACK: begin
          if (spec_c) begin
            result        <= spec_res;
            flag_invalid  <= spec_inv;
            flag_overflow <= 1'b0;
            flag_inexact  <= 1'b0;
            m_r           <= '0;
            state         <= ROUND;
          end else begin
            sign_r  <= lsign;
            eff_sub <= a_q.sign ^ b_q.sign;
            exp_r   <= EW'(e_l);
            m_r     <= {1'b0, sig_l};
            cnt     <= diff;
            if (far) begin
              s_r   <= (sig_s != '0) ? SW'(1) : '0;
              state <= ADD;
            end else begin
              s_r   <= sig_s;
              state <= (diff == '0) ? ADD : ALIGN;
            end
          end
        end
        ALIGN: begin
          s_r <= {1'b0, s_r[SW-1:2], s_r[1] | s_r[0]};
          cnt <= cnt - EXPBITS'(1);
          if (cnt == EXPBITS'(1)) state <= ADD;
        end
        ADD: begin
          m_r <= sum_c;
          if (sum_c == '0) begin
            if (eff_sub) sign_r <= 1'b0;
            state <= ROUND;
          end else begin
            state <= need_norm(sum_c, exp_r) ? NORM : ROUND;
          end
        end
        NORM: begin
          m_r   <= m_n;
          exp_r <= e_n;
          state <= need_norm(m_n, e_n) ? NORM : ROUND;
        end
        ROUND: begin
          if (!(a_nan | b_nan | a_inf | b_inf)) begin
            flag_invalid <= 1'b0;
            if (tiny) begin
              result        <= {sign_r, {(W-1){1'b0}}};
              flag_overflow <= 1'b0;
              flag_inexact  <= 1'b1;
            end else if (ovf) begin
              result        <= {sign_r, {EXPBITS{1'b1}}, {FRACBITS{1'b0}}};
              flag_overflow <= 1'b1;
              flag_inexact  <= 1'b1;
            end else begin
              result        <= {sign_r, exp_field, rnd[FRACBITS-1:0]};
              flag_overflow <= 1'b0;
              flag_inexact  <= rnd_inexact;
            end
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder_seq.sv
// Directed-vector bench for fp_adder_seq (binary32 configuration).
module tb_fp_adder_seq;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_ready, sub, out_valid, out_ready;
  logic        flag_invalid, flag_overflow, flag_inexact;
  logic [31:0] a, b, result;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  fp_adder_seq #(.EXPBITS(8), .FRACBITS(23)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .sub          (sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag_invalid (flag_invalid),
    .flag_overflow(flag_overflow),
    .flag_inexact (flag_inexact)
  );

  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vs);
    @(negedge clock);
    a = va; b = vb; sub = vs; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic accept();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL reset handshake: got %b want 10", {in_ready, out_valid});
    end
    n_vec++;
    if ({result, flag_invalid, flag_overflow, flag_inexact} !== 35'd0) begin
      n_err++; $display("FAIL reset outputs: result %h flags %b", result,
                        {flag_invalid, flag_overflow, flag_inexact});
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_one_plus_one();
    int cyc;
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    wait_out(cyc);
    n_vec++;
    if (cyc !== 4) begin n_err++; $display("FAIL one_plus_one latency: got %0d want 4", cyc); end
    n_vec++;
    if (result !== 32'h40000000) begin
      n_err++; $display("FAIL one_plus_one result: got %h want 40000000", result);
    end
    n_vec++;
    if ({flag_invalid, flag_overflow, flag_inexact} !== 3'b000) begin
      n_err++; $display("FAIL one_plus_one flags: got %b want 000",
                        {flag_invalid, flag_overflow, flag_inexact});
    end
    accept();
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL one_plus_one release: got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_align_tie();
    int cyc;
    issue(32'h3F800000, 32'h33800000, 1'b0);
    wait_out(cyc);
    n_vec++;
    if (cyc !== 27) begin n_err++; $display("FAIL align_tie latency: got %0d want 27", cyc); end
    n_vec++;
    if (result !== 32'h3F800000) begin
      n_err++; $display("FAIL align_tie result: got %h want 3f800000", result);
    end
    n_vec++;
    if ({flag_invalid, flag_overflow, flag_inexact} !== 3'b001) begin
      n_err++; $display("FAIL align_tie flags: got %b want 001",
                        {flag_invalid, flag_overflow, flag_inexact});
    end
    accept();
  endtask

  task automatic test_inf_invalid();
    int cyc;
    issue(32'h7F800000, 32'hFF800000, 1'b0);
    wait_out(cyc);
    n_vec++;
    if (cyc !== 2) begin n_err++; $display("FAIL inf_invalid latency: got %0d want 2", cyc); end
    n_vec++;
    if (result !== 32'h7FC00000) begin
      n_err++; $display("FAIL inf_invalid result: got %h want 7fc00000", result);
    end
    n_vec++;
    if ({flag_invalid, flag_overflow, flag_inexact} !== 3'b100) begin
      n_err++; $display("FAIL inf_invalid flags: got %b want 100",
                        {flag_invalid, flag_overflow, flag_inexact});
    end
    accept();
  endtask

  task automatic test_nan();
    int cyc;
    issue(32'hFFC00123, 32'h3F800000, 1'b0);
    wait_out(cyc);
    n_vec++;
    if (result !== 32'h7FC00000 || flag_invalid !== 1'b0) begin
      n_err++; $display("FAIL nan result: got %h inv %b want 7fc00000 inv 0", result, flag_invalid);
    end
    accept();
  endtask

  task automatic test_overflow();
    int cyc;
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    wait_out(cyc);
    n_vec++;
    if (result !== 32'h7F800000) begin
      n_err++; $display("FAIL overflow result: got %h want 7f800000", result);
    end
    n_vec++;
    if ({flag_invalid, flag_overflow, flag_inexact} !== 3'b011) begin
      n_err++; $display("FAIL overflow flags: got %b want 011",
                        {flag_invalid, flag_overflow, flag_inexact});
    end
    accept();
  endtask

  task automatic test_left_norm();
    int cyc;
    issue(32'h3F800000, 32'h3F400000, 1'b1);
    wait_out(cyc);
    n_vec++;
    if (cyc !== 6) begin n_err++; $display("FAIL left_norm latency: got %0d want 6", cyc); end
    n_vec++;
    if (result !== 32'h3E800000 || flag_inexact !== 1'b0) begin
      n_err++; $display("FAIL left_norm result: got %h inx %b want 3e800000 inx 0",
                        result, flag_inexact);
    end
    accept();
  endtask

  task automatic test_abort();
    int cyc;
    issue(32'h3F800000, 32'h33800000, 1'b0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL abort handshake: got %b want 10", {in_ready, out_valid});
    end
    n_vec++;
    if ({result, flag_invalid, flag_overflow, flag_inexact} !== 35'd0) begin
      n_err++; $display("FAIL abort outputs: result %h flags %b", result,
                        {flag_invalid, flag_overflow, flag_inexact});
    end
    @(negedge clock);
    reset_n = 1'b1;
    issue(32'h3F800000, 32'h33800000, 1'b0);
    wait_out(cyc);
    n_vec++;
    if (cyc !== 27 || result !== 32'h3F800000 || flag_inexact !== 1'b1) begin
      n_err++; $display("FAIL abort rerun: lat %0d result %h inx %b want 27 3f800000 1",
                        cyc, result, flag_inexact);
    end
    accept();
  endtask

  task automatic test_cancel_hold();
    int cyc;
    issue(32'h3FC00000, 32'h3FC00000, 1'b1);
    wait_out(cyc);
    n_vec++;
    if (cyc !== 3) begin n_err++; $display("FAIL cancel latency: got %0d want 3", cyc); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (result !== 32'h00000000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL cancel hold %0d: result %h valid %b ready %b want 0 1 0",
                          i, result, out_valid, in_ready);
      end
      @(posedge clock); #1;
    end
    n_vec++;
    if ({flag_invalid, flag_overflow, flag_inexact} !== 3'b000) begin
      n_err++; $display("FAIL cancel flags: got %b want 000",
                        {flag_invalid, flag_overflow, flag_inexact});
    end
    accept();
  endtask

  task automatic test_denorm();
    int cyc;
    logic [31:0] want;
`ifdef FP_ADDER_DENORM_EN
    want = 32'h00000002;
`else
    want = 32'h00000000;
`endif
    issue(32'h00000001, 32'h00000001, 1'b0);
    wait_out(cyc);
    n_vec++;
    if (result !== want || flag_inexact !== 1'b0) begin
      n_err++; $display("FAIL denorm result: got %h inx %b want %h inx 0", result, flag_inexact, want);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(32'h40000000, 32'h3F800000, 1'b0);
    wait_out(cyc);
    accept();
    issue(32'hC0400000, 32'h3F800000, 1'b0);
    wait_out(cyc);
    n_vec++;
    if (result !== 32'hC0000000) begin
      n_err++; $display("FAIL back_to_back result: got %h want c0000000", result);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_one_plus_one();
    test_align_tie();
    test_inf_invalid();
    test_nan();
    test_overflow();
    test_left_norm();
    test_abort();
    test_cancel_hold();
    test_denorm();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
